// File: rtl/uart_defs.sv
// uart_defs: shared UART frame defaults and the one-hot receiver state encoding.
package uart_defs;
    localparam int SIZE_DEF    = 8;
    localparam int SB_TICK_DEF = 16;
    localparam int DIVISOR_DEF = 163;

    typedef enum logic [4:0] {
        IDLE  = 5'b00001,
        START = 5'b00010,
        DATA  = 5'b00100,
        STOP  = 5'b01000,
        ERROR = 5'b10000
    } state_t;
endpackage

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: free-running divider giving a one-clk tick every DIVISOR clocks.
module baud_tick_gen #(
    parameter int DIVISOR = uart_defs::DIVISOR_DEF
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

    logic [CW-1:0] cnt_q;

    assign tick = cnt_q == LAST;

    always_ff @(posedge clk or posedge reset)
        if (reset) cnt_q <= '0;
        else       cnt_q <= tick ? '0 : cnt_q + CW'(1);
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, 16x oversampled; rx_done is a level held until the next start edge.
module uart_rx
    import uart_defs::*;
#(
    parameter int SIZE    = SIZE_DEF,
    parameter int SB_TICK = SB_TICK_DEF,
    parameter int DIVISOR = DIVISOR_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    output logic [SIZE-1:0] d_out,
    output logic            rx_done,
    output logic            frame_err
);
    localparam int NW = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [3:0]    S_MID  = 4'd7;
    localparam logic [3:0]    S_LAST = 4'd15;
    localparam logic [3:0]    S_STOP = 4'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(SIZE - 1);

    logic            tick;
    logic            rx_meta_q, rx_s_q;
    state_t          state_q, state_d;
    logic [3:0]      s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [SIZE-1:0] sh_q, sh_d, d_out_q, d_out_d;
    logic            rx_done_q, rx_done_d, frame_err_q, frame_err_d;

    baud_tick_gen #(.DIVISOR(DIVISOR)) u_tick (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    assign d_out     = d_out_q;
    assign rx_done   = rx_done_q;
    assign frame_err = frame_err_q;

    always_ff @(posedge clk or posedge reset)
        if (reset) {rx_s_q, rx_meta_q} <= 2'b11;
        else       {rx_s_q, rx_meta_q} <= {rx_meta_q, rx};

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state_q     <= IDLE;
            s_q         <= '0;
            n_q         <= '0;
            sh_q        <= '0;
            d_out_q     <= '0;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            n_q         <= n_d;
            sh_q        <= sh_d;
            d_out_q     <= d_out_d;
            rx_done_q   <= rx_done_d;
            frame_err_q <= frame_err_d;
        end

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        n_d         = n_q;
        sh_d        = sh_q;
        d_out_d     = d_out_q;
        rx_done_d   = rx_done_q;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE:
                if (!rx_s_q) begin
                    state_d   = START;
                    s_d       = '0;
                    rx_done_d = 1'b0;
                end
            START:
                if (tick) begin
                    if (s_q == S_MID) begin
                        // a start bit that is high again at mid-bit was only a glitch
                        state_d = rx_s_q ? IDLE : DATA;
                        s_d     = '0;
                        n_d     = '0;
                    end else s_d = s_q + 4'd1;
                end
            DATA:
                if (tick) begin
                    if (s_q == S_LAST) begin
                        sh_d = {rx_s_q, sh_q[SIZE-1:1]};
                        s_d  = '0;
                        if (n_q == N_LAST) state_d = STOP;
                        else               n_d = n_q + NW'(1);
                    end else s_d = s_q + 4'd1;
                end
            STOP:
                if (tick) begin
                    if (s_q == S_STOP) begin
                        state_d     = rx_s_q ? IDLE : ERROR;
                        d_out_d     = rx_s_q ? sh_q : d_out_q;
                        rx_done_d   = rx_s_q | rx_done_q;
                        frame_err_d = !rx_s_q;
                    end else s_d = s_q + 4'd1;
                end
            ERROR:
                if (rx_s_q) state_d = IDLE;
            default:
                state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames with a queue-based scoreboard checked by an rx_done/frame_err monitor.
module tb_uart_rx;
    localparam int BIT = 64;

    typedef struct packed {
        logic       err;
        logic [7:0] d;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic [7:0] d_out;
    logic       rx_done;
    logic       frame_err;

    ev_t q[$];
    ev_t mon_e;
    int  checks = 0;
    int  errors = 0;
    bit  done_prev = 1'b0;
    bit  fe_chk = 1'b0;

    uart_rx #(.SIZE(8), .SB_TICK(16), .DIVISOR(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .d_out    (d_out),
        .rx_done  (rx_done),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, pending=%0d", q.size());
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (fe_chk) begin
            checks++;
            if (frame_err) begin
                errors++;
                $display("FAIL frame_err_width: frame_err=%b required 0 one clk after pulse", frame_err);
            end
            fe_chk = 1'b0;
        end
        if ((rx_done && !done_prev) || frame_err) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: rx_done=%b frame_err=%b d_out=%h with nothing expected",
                         rx_done, frame_err, d_out);
            end else begin
                mon_e = q.pop_front();
                if (mon_e.err != frame_err || d_out != mon_e.d || (frame_err && rx_done)) begin
                    errors++;
                    $display("FAIL event: got frame_err=%b rx_done=%b d_out=%h, required frame_err=%b rx_done=%b d_out=%h",
                             frame_err, rx_done, d_out, mon_e.err, !mon_e.err, mon_e.d);
                end
            end
            if (frame_err) fe_chk = 1'b1;
        end
        done_prev = rx_done;
    end

    task automatic drive(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input logic stop, input bit win, input bit exp);
        if (exp) q.push_back('{1'b0, b});
        drive(1'b0, BIT);
        for (int i = 0; i < 8; i++)
            if (win) begin
                drive(~b[i], 26);
                drive(b[i], 12);
                drive(~b[i], 26);
            end else drive(b[i], BIT);
        drive(stop, BIT);
    endtask

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, want);
        end
    endtask

    initial begin
        logic [7:0] c3;
        c3 = 8'hC3;
        repeat (3) @(negedge clk);
        check("reset_d_out", d_out, 8'h00);
        check("reset_rx_done", {7'd0, rx_done}, 8'h00);
        check("reset_frame_err", {7'd0, frame_err}, 8'h00);
        reset = 1'b0;
        drive(1'b1, 20);

        send(8'h5A, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 200);
        check("hold_rx_done", {7'd0, rx_done}, 8'h01);
        check("hold_d_out", d_out, 8'h5A);

        send(8'h03, 1'b1, 1'b0, 1'b1);
        send(8'h02, 1'b1, 1'b0, 1'b1);
        send(8'h00, 1'b1, 1'b0, 1'b1);
        drive(1'b1, BIT);

        send(8'h00, 1'b1, 1'b1, 1'b1);
        send(8'hFF, 1'b1, 1'b1, 1'b1);
        drive(1'b1, BIT);

        drive(1'b0, 16);
        drive(1'b1, 2 * BIT);
        check("glitch_rx_done", {7'd0, rx_done}, 8'h00);
        check("glitch_d_out", d_out, 8'hFF);

        q.push_back('{1'b1, 8'hFF});
        send(8'hFF, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 2 * BIT);
        drive(1'b1, BIT);
        send(8'h81, 1'b1, 1'b0, 1'b1);
        drive(1'b1, BIT);

        drive(1'b0, BIT);
        for (int i = 0; i < 3; i++) drive(c3[i], BIT);
        drive(c3[3], BIT / 2);
        reset = 1'b1;
        #1;
        check("abort_d_out", d_out, 8'h00);
        check("abort_rx_done", {7'd0, rx_done}, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 2 * BIT);
        send(8'hA5, 1'b1, 1'b0, 1'b1);
        drive(1'b1, BIT);

        for (int i = 0; i < 300 && q.size() != 0; i++) @(negedge clk);
        check("pending_events", 8'(q.size()), 8'h00);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
